// File: rtl/fifo_word_packer.sv
// Pops WIDTH-bit entries from a registered-output FIFO and packs PACK of them into one valid/ready word.
// Define PACKER_CHECKS_EN to enable simulation-only protocol and state checks.
module fifo_word_packer #(
   parameter int WIDTH = 8,
   parameter int PACK  = 4,
   parameter int CW    = $clog2(PACK + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [WIDTH-1:0]      fifo_dout,
   output logic                  fifo_rd_en,
   input  logic                  flush,
   output logic [WIDTH*PACK-1:0] out_data,
   output logic [CW-1:0]         out_count,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam logic [0:0]    ST_FILL = 1'b0;
   localparam logic [0:0]    ST_HOLD = 1'b1;
   localparam logic [CW-1:0] PACK_C  = CW'(PACK);

   logic [0:0]            state_q, state_d;
   logic [CW-1:0]         issued_q, issued_d;
   logic [CW-1:0]         captured_q, captured_d;
   logic                  inflight_q, inflight_d;
   logic                  flush_pend_q, flush_pend_d;
   logic [WIDTH*PACK-1:0] lanes_q, lanes_d;
   logic                  flush_accept;

   // Reset gates the pop request so the FIFO is never drained while the packer is held in reset.
   assign fifo_rd_en = !rst && (state_q == ST_FILL) && !fifo_empty &&
                       (issued_q < PACK_C) && !flush_pend_q;

   assign flush_accept = flush && (state_q == ST_FILL) &&
                         ((captured_q != '0) || inflight_q);

   always_comb begin
      state_d      = state_q;
      issued_d     = issued_q;
      captured_d   = captured_q;
      inflight_d   = inflight_q;
      flush_pend_d = flush_pend_q;
      lanes_d      = lanes_q;
      if (state_q == ST_FILL) begin
         issued_d     = issued_q + CW'(fifo_rd_en);
         inflight_d   = fifo_rd_en;
         flush_pend_d = flush_pend_q | flush_accept;
         if (inflight_q) begin
            for (int unsigned k = 0; k < PACK; k++) begin
               if (captured_q == CW'(k)) lanes_d[k*WIDTH +: WIDTH] = fifo_dout;
            end
            captured_d = captured_q + CW'(1);
         end
         // A completed word wins over a pending flush; otherwise flush waits for the last read to land.
         if ((captured_d == PACK_C) || (flush_pend_d && !inflight_d)) begin
            state_d = ST_HOLD;
         end
      end else if (out_ready) begin
         state_d      = ST_FILL;
         issued_d     = '0;
         captured_d   = '0;
         flush_pend_d = 1'b0;
         lanes_d      = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_FILL;
         issued_q     <= '0;
         captured_q   <= '0;
         inflight_q   <= 1'b0;
         flush_pend_q <= 1'b0;
         lanes_q      <= '0;
      end else begin
         state_q      <= state_d;
         issued_q     <= issued_d;
         captured_q   <= captured_d;
         inflight_q   <= inflight_d;
         flush_pend_q <= flush_pend_d;
         lanes_q      <= lanes_d;
      end
   end

   assign out_valid = (state_q == ST_HOLD);
   assign out_data  = out_valid ? lanes_q : '0;
   assign out_count = out_valid ? captured_q : '0;

`ifdef PACKER_CHECKS_EN
   always @(posedge clk) begin
      if (!rst) begin
         if (fifo_rd_en && fifo_empty)
            $error("ERROR: [PACKER_UNDERFLOW] Module=fifo_word_packer Time=%0t", $time);
         if (inflight_q && (state_q == ST_FILL) && $isunknown(fifo_dout))
            $error("ERROR: [PACKER_X_DATA] Module=fifo_word_packer Time=%0t", $time);
         if (flush && !flush_accept)
            $warning("WARNING: [PACKER_FLUSH_IGNORED] Module=fifo_word_packer Time=%0t", $time);
         if (({1'b0, captured_q} > {1'b0, PACK_C}) ||
             ({1'b0, issued_q} > ({1'b0, captured_q} + (CW+1)'(1))))
            $error("ERROR: [PACKER_STATE] Module=fifo_word_packer Time=%0t", $time);
      end
   end
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer: a behavioural FIFO feeds the DUT, expected words are queued by
// the stimulus and checked by an independent output monitor.
module tb_fifo_word_packer;

   localparam int WIDTH = 8;
   localparam int PACK  = 4;
   localparam int CW    = $clog2(PACK + 1);

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  fifo_empty;
   logic [WIDTH-1:0]      fifo_dout = '0;
   logic                  fifo_rd_en;
   logic                  flush;
   logic [WIDTH*PACK-1:0] out_data;
   logic [CW-1:0]         out_count;
   logic                  out_valid;
   logic                  out_ready;

   typedef struct {
      logic [31:0] data;
      logic [31:0] count;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] mem[256];
   int         wr_ptr    = 0;
   int         rd_ptr    = 0;
   int         pop_cnt   = 0;
   int         valid_cyc = 0;
   int         errors    = 0;
   int         checks    = 0;

   fifo_word_packer #(.WIDTH(WIDTH), .PACK(PACK)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (fifo_rd_en),
      .flush      (flush),
      .out_data   (out_data),
      .out_count  (out_count),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;

   // Behavioural FIFO with registered read data.
   assign fifo_empty = (wr_ptr == rd_ptr);
   always @(posedge clk) begin
      if (fifo_rd_en && !fifo_empty) begin
         fifo_dout <= mem[rd_ptr % 256];
         rd_ptr    <= rd_ptr + 1;
         pop_cnt   <= pop_cnt + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr % 256] = b;
      wr_ptr++;
   endtask

   task automatic expect_word(input logic [31:0] d, input int c);
      exp_t e;
      e.data  = d;
      e.count = c;
      exp_q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d words pending, required 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (2) cyc();
   endtask

   task automatic wait_valid(input string name);
      int i;
      i = 0;
      while (!out_valid && i < 100) begin
         @(negedge clk);
         i++;
      end
      if (!out_valid) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got out_valid=0, required 1", name);
      end
   endtask

   // Output monitor: compares every presented word against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && fifo_rd_en) chk("no_underflow", {31'd0, fifo_empty}, 32'd0);
      if (!rst && out_valid) begin
         valid_cyc++;
         chk("no_pop_in_hold", {31'd0, fifo_rd_en}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_word: got data=%h count=%0d, required no word", out_data, out_count);
         end else begin
            chk("out_data", out_data, exp_q[0].data);
            chk("out_count", {29'd0, out_count}, exp_q[0].count);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      rst       = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b1;

      // Test 1: full word at full rate
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      repeat (3) cyc();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_count", {29'd0, out_count}, 32'd0);
      chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      expect_word(32'h44332211, 4);
      valid_cyc = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rd_en_burst", {31'd0, fifo_rd_en}, 32'd1);
      end
      @(negedge clk);
      chk("rd_en_stop", {31'd0, fifo_rd_en}, 32'd0);
      drain("t1");
      chk("valid_one_cycle", valid_cyc, 32'd1);

      // Test 2: backpressure holds the word
      cyc();
      out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) push(8'(i));
      expect_word(32'h04030201, 4);
      expect_word(32'h08070605, 4);
      repeat (10) cyc();
      out_ready = 1'b1;
      drain("t2");

      // Test 3: flush with FIFO empty
      push(8'hAA); push(8'hBB);
      expect_word(32'h0000BBAA, 2);
      repeat (5) cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      drain("t3a");
      push(8'hCC); push(8'hDD); push(8'hEE); push(8'hFF);
      expect_word(32'hFFEEDDCC, 4);
      drain("t3b");

      // Test 4: flush on the second pop waits for the in-flight entry
      p0 = pop_cnt;
      push(8'h51); push(8'h52); push(8'h53);
      expect_word(32'h00005251, 2);
      cyc();
      chk("second_pop", {31'd0, fifo_rd_en}, 32'd1);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      wait_valid("t4");
      chk("flush_pop_count", pop_cnt - p0, 32'd2);
      drain("t4a");
      push(8'h54); push(8'h55); push(8'h56);
      expect_word(32'h56555453, 4);
      drain("t4b");

      // Test 5: ignored flushes
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      repeat (5) cyc();
      chk("idle_flush_valid", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b0;
      push(8'h61); push(8'h62); push(8'h63); push(8'h64);
      expect_word(32'h64636261, 4);
      wait_valid("t5");
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      repeat (3) cyc();
      out_ready = 1'b1;
      drain("t5");
      chk("hold_flush_no_extra", {31'd0, out_valid}, 32'd0);

      // Test 6: asynchronous reset mid-word and during HOLD
      push(8'h71); push(8'h72); push(8'h73);
      repeat (6) cyc();
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_data", out_data, 32'd0);
      chk("arst_count", {29'd0, out_count}, 32'd0);
      chk("arst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      cyc();
      rst = 1'b0;
      push(8'h81); push(8'h82); push(8'h83); push(8'h84);
      expect_word(32'h84838281, 4);
      drain("t6a");
      out_ready = 1'b0;
      push(8'h91); push(8'h92); push(8'h93); push(8'h94);
      expect_word(32'h94939291, 4);
      wait_valid("t6b");
      #1 rst = 1'b1;
      #1;
      chk("hold_arst_valid", {31'd0, out_valid}, 32'd0);
      chk("hold_arst_data", out_data, 32'd0);
      chk("hold_arst_count", {29'd0, out_count}, 32'd0);
      exp_q.delete();
      cyc();
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (4) cyc();
      chk("post_rst_idle", {31'd0, out_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Downstream consumer of the team's synchronous FIFO. It pops WIDTH-bit entries through the FIFO read interface (rd_en / empty / registered dout) and packs PACK consecutive entries into one wide word.
- The packed word goes out on a valid/ready stream toward the next processing stage.
- It manages FIFO read latency and output backpressure, and supports a flush to emit a partially filled word.

Parameters:
- WIDTH, 8: bits per FIFO entry; must match the FIFO's WIDTH.
- PACK, 4: entries per output word; legal range 2..8.
- CW, $clog2(PACK+1): width of out_count; derived, not to be overridden.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- rst, input, 1: asynchronous, active-high reset.
- fifo_empty, input, 1: FIFO empty flag.
- fifo_dout, input, WIDTH: FIFO read data; valid the cycle after fifo_rd_en.
- fifo_rd_en, output, 1: FIFO pop request.
- flush, input, 1: single-cycle request to emit the current partial word.
- out_data, output, WIDTH*PACK: packed word; entry k occupies bits [k*WIDTH +: WIDTH], and the first-popped entry is k=0.
- out_count, output, CW: number of valid entries in out_data (1..PACK).
- out_valid, output, 1: out_data/out_count valid.
- out_ready, input, 1: downstream accepts when out_valid && out_ready.

Behaviour:
- Reset (asynchronous, any time, including mid-word or mid-read):
  - state=FILL, issued=0, captured=0, inflight=0, flush_pend=0.
  - out_valid=0, out_data=0, out_count=0, fifo_rd_en=0.
  - Partial data is discarded.
- States:
  - FILL: popping entries.
  - HOLD: word presented on output.
- fifo_rd_en is combinational: (state==FILL) && !fifo_empty && (issued<PACK) && !flush_pend.
  - It is never asserted while fifo_empty=1 or in HOLD.
  - Each assertion increments issued and sets inflight for the next cycle.
- Capture:
  - The cycle after fifo_rd_en, fifo_dout is written into lane[captured] at the clock edge.
  - captured then increments.
  - Back-to-back pops occur at 1 entry/cycle.
- FILL -> HOLD, full word: when captured reaches PACK.
  - out_valid=1, out_count=PACK.
  - Latency: pops in cycles 0..PACK-1 give out_valid high in cycle PACK+1.
- FILL -> HOLD, flush:
  - Flush in FILL with captured+inflight>0 sets flush_pend.
  - No further pops are issued.
  - Once inflight=0, the block enters HOLD with out_count=captured.
  - Unfilled lanes are driven 0.
- Flush edge cases:
  - Flush with captured=0 and inflight=0 is ignored.
  - Flush in HOLD is ignored.
  - Flush coincident with a capture that completes the word is absorbed (a full word is emitted).
- HOLD:
  - out_data/out_count are held stable while out_valid && !out_ready.
  - On handshake: out_valid=0 next cycle, and issued, captured and flush_pend clear.
  - The next cycle returns to FILL, with pops resuming that cycle.
  - No pops occur during HOLD (no overlap).
- Counters:
  - issued/captured are CW bits wide and saturate logically at PACK.
  - captured <= issued <= captured+1 at all times.
- FIFO empty mid-word: stall in FILL indefinitely with partial data retained; no timeout.

Optional Feature:
- Macro: PACKER_CHECKS_EN.
- Defined: simulation checks in the codebase message format.
  - $error "ERROR: [PACKER_UNDERFLOW] Module=fifo_word_packer Time=%0t" if fifo_rd_en && fifo_empty.
  - $error "[PACKER_X_DATA]" if a captured fifo_dout contains X/Z.
  - $warning "[PACKER_FLUSH_IGNORED]" on an ignored flush.
  - $error "[PACKER_STATE]" if captured>PACK or issued>captured+1.
- Undefined: no checks; RTL functionally identical.

Test Plan:
1. Reset, FIFO preloaded with 11,22,33,44, out_ready=1 -> fifo_rd_en high 4 consecutive cycles; out_data=0x44332211, out_count=4, out_valid for 1 cycle.
2. Preload 8 entries 01..08, out_ready=0 for 10 cycles, then 1 -> first word 0x04030201 held stable, no pops during HOLD; then 0x08070605 follows.
3. Push AA,BB, then pulse flush with FIFO empty -> out_data=0x0000BBAA, out_count=2; a later push of CC begins a new word at lane 0.
4. Pulse flush the same cycle as the 2nd pop (inflight=1) -> flush waits one cycle; out_count=2 with both entries present; no third pop.
5. Flush at idle (captured=0) and flush during HOLD -> no output change; with PACKER_CHECKS_EN, [PACKER_FLUSH_IGNORED] is reported.
6. Assert rst after 3 of 4 entries are captured -> all outputs 0 immediately (asynchronous); the next 4 entries form a clean word starting at lane 0.
